perf_stats_collector: RTL and testbench

- Upstream stage of the system status register. Accumulates per-core retirement, L1 access/hit, stall and branch events over fixed windows of 2^WINDOW_LOG2 cycles.
- At each window end it computes IPC (Q8.4), L1 hit rate (percent) and three health flags. It publishes them as registered values that feed the status packer's current_ipc_calculated_i, cache_hit_rate_l1_i, any_core_active_i, pipeline_bottleneck_i, high_power_mode_i and good_bp_i inputs.

---
 rtl/riscv_core_pkg.sv | 23 ++
 rtl/perf_div_unit.sv | 63 ++++++
 rtl/perf_stats_collector.sv | 155 +++++++++++++++
 tb/tb_perf_stats_collector.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_pkg.sv
// Shared core-level definitions: performance-collector FSM states, latencies and helpers.
package riscv_core_pkg;

  localparam int DEFAULT_NUM_CORES    = 4;
  localparam int PERF_Q_FRAC_BITS     = 4;
  localparam int PERF_DIV_LATENCY     = 8;
  localparam int PERF_PUBLISH_LATENCY = 10;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DIVIDE,
    PUBLISH
  } perf_state_e;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/perf_div_unit.sv
// Restoring divider producing an 8-bit quotient, one quotient bit per cycle.
// The first bit is resolved on the start edge, so done pulses PERF_DIV_LATENCY cycles after start.
module perf_div_unit
  import riscv_core_pkg::*;
#(
  parameter int DIVIDEND_W = 22
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVIDEND_W-1:0] divisor,
  output logic                  done,
  output logic [7:0]            quotient
);

  localparam int WIDE_W = DIVIDEND_W + 8;

  logic [DIVIDEND_W-1:0] rem_q, dvs_q, cur_rem, cur_dvs, rem_next;
  logic [2:0]            idx_q, cur_idx;
  logic                  busy_q, take;
  logic [WIDE_W-1:0]     trial;

  // One restoring step: subtract divisor<<idx when it fits. Quotient < 256 keeps 8 steps exact.
  always_comb begin
    cur_rem  = start ? dividend : rem_q;
    cur_dvs  = start ? divisor : dvs_q;
    cur_idx  = start ? 3'(PERF_DIV_LATENCY - 1) : idx_q;
    trial    = {8'b0, cur_dvs} << cur_idx;
    take     = {8'b0, cur_rem} >= trial;
    rem_next = take ? cur_rem - trial[DIVIDEND_W-1:0] : cur_rem;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q    <= '0;
      dvs_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q    <= rem_next;
        dvs_q    <= divisor;
        idx_q    <= cur_idx - 3'd1;
        busy_q   <= 1'b1;
        quotient <= {take, 7'b0};
      end else if (busy_q) begin
        rem_q           <= rem_next;
        quotient[idx_q] <= take;
        idx_q           <= idx_q - 3'd1;
        if (idx_q == 3'd0) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/perf_stats_collector.sv
// Windowed per-core performance statistics: IPC, L1 hit rate and health flags,
// published together 10 cycles after each window's final cycle.
module perf_stats_collector
  import riscv_core_pkg::*;
#(
  parameter int          NUM_CORES      = DEFAULT_NUM_CORES,
  parameter int          WINDOW_LOG2    = 10,
  parameter logic [11:0] HIGH_POWER_IPC = 12'h018
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [NUM_CORES-1:0] core_active_i,
  input  logic [NUM_CORES-1:0] instr_retired_i,
  input  logic [NUM_CORES-1:0] l1_access_i,
  input  logic [NUM_CORES-1:0] l1_hit_i,
  input  logic [NUM_CORES-1:0] stall_i,
  input  logic [NUM_CORES-1:0] branch_resolved_i,
  input  logic [NUM_CORES-1:0] branch_mispredict_i,
  output logic [31:0]          current_ipc_o,
  output logic [7:0]           cache_hit_rate_l1_o,
  output logic                 any_core_active_o,
  output logic                 pipeline_bottleneck_o,
  output logic                 high_power_mode_o,
  output logic                 good_bp_o,
  output logic                 window_valid_o
);

  localparam int          CNT_W      = WINDOW_LOG2 + 5;
  localparam int          DIV_W      = CNT_W + 7;
  localparam int          IPC_SHIFT  = WINDOW_LOG2 - PERF_Q_FRAC_BITS;
  localparam logic [31:0] STALL_TH   = 32'(NUM_CORES) << (WINDOW_LOG2 - 1);
  // Snapshot edge + DIVIDE cycles + PUBLISH cycle add up to the publish latency.
  localparam int          DIV_PHASES = PERF_PUBLISH_LATENCY - 2;
  localparam int          PH_W       = $clog2(DIV_PHASES);

  typedef struct packed {
    logic [CNT_W-1:0] ret;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] hit;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] br;
    logic [CNT_W-1:0] mp;
  } perf_cnt_t;

  perf_state_e            state_q, state_d;
  logic [WINDOW_LOG2-1:0] cyc_q;
  logic [PH_W-1:0]        phase_q;
  perf_cnt_t              cnt_q, cnt_sum, shadow_q;
  logic                   counting, win_end, publish, div_start, div_done;
  logic [7:0]             div_quotient;
  logic [CNT_W-1:0]       ipc_shift;
  logic [11:0]            ipc_val;

  assign counting = enable_i && (state_q != IDLE);
  assign win_end  = counting && (&cyc_q);

  always_comb begin
    cnt_sum.ret   = cnt_q.ret   + CNT_W'(popcount16(16'(instr_retired_i)));
    cnt_sum.acc   = cnt_q.acc   + CNT_W'(popcount16(16'(l1_access_i)));
    cnt_sum.hit   = cnt_q.hit   + CNT_W'(popcount16(16'(l1_access_i & l1_hit_i)));
    cnt_sum.stall = cnt_q.stall + CNT_W'(popcount16(16'(stall_i)));
    cnt_sum.br    = cnt_q.br    + CNT_W'(popcount16(16'(branch_resolved_i)));
    cnt_sum.mp    = cnt_q.mp    + CNT_W'(popcount16(16'(branch_resolved_i & branch_mispredict_i)));
    ipc_shift     = shadow_q.ret >> IPC_SHIFT;
    ipc_val       = (32'(ipc_shift) > 32'hFFF) ? 12'hFFF : 12'(ipc_shift);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      cyc_q    <= '0;
    end else if (!counting) begin
      cnt_q <= '0;
      cyc_q <= '0;
    end else if (win_end) begin
      shadow_q <= cnt_sum;
      cnt_q    <= '0;
      cyc_q    <= '0;
    end else begin
      cnt_q <= cnt_sum;
      cyc_q <= cyc_q + WINDOW_LOG2'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= (state_q == DIVIDE) ? phase_q + PH_W'(1) : '0;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    publish   = 1'b0;
    div_start = 1'b0;
    case (state_q)
      IDLE:    if (enable_i) state_d = COUNT;
      COUNT: begin
        if (!enable_i)   state_d = IDLE;
        else if (win_end) state_d = DIVIDE;
      end
      DIVIDE: begin
        div_start = (phase_q == '0) && (shadow_q.acc != '0);
        if (!enable_i)                          state_d = IDLE;
        else if (phase_q == PH_W'(DIV_PHASES - 1)) state_d = PUBLISH;
      end
      PUBLISH: begin
        publish = enable_i;
        state_d = enable_i ? COUNT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  perf_div_unit #(.DIVIDEND_W(DIV_W)) u_div (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start    (div_start),
    .dividend (DIV_W'(shadow_q.hit) * DIV_W'(100)),
    .divisor  (DIV_W'(shadow_q.acc)),
    .done     (div_done),
    .quotient (div_quotient)
  );

  // A skipped divide (zero accesses) never raises done, which yields the 0% rate.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      current_ipc_o         <= '0;
      cache_hit_rate_l1_o   <= '0;
      any_core_active_o     <= 1'b0;
      pipeline_bottleneck_o <= 1'b0;
      high_power_mode_o     <= 1'b0;
      good_bp_o             <= 1'b0;
      window_valid_o        <= 1'b0;
    end else begin
      any_core_active_o <= |core_active_i;
      window_valid_o    <= publish;
      if (publish) begin
        current_ipc_o         <= 32'(ipc_val);
        cache_hit_rate_l1_o   <= div_done ? div_quotient : 8'd0;
        pipeline_bottleneck_o <= 32'(shadow_q.stall) >= STALL_TH;
        high_power_mode_o     <= ipc_val >= HIGH_POWER_IPC;
        good_bp_o             <= (shadow_q.br != '0) &&
                                 ((32'(shadow_q.mp) << 4) < 32'(shadow_q.br));
      end
    end
  end

endmodule

// File: tb/tb_perf_stats_collector.sv
// Scoreboard bench for perf_stats_collector: window-level reference model feeds an
// expectation queue; a monitor pops and compares on every window_valid_o pulse.
module tb_perf_stats_collector;

  localparam int          NC  = 2;
  localparam int          WL  = 6;
  localparam int          WIN = 1 << WL;
  localparam logic [11:0] HP  = 12'h018;

  logic          clk = 1'b0;
  logic          rst, enable;
  logic [NC-1:0] core_active, retired, l1_access, l1_hit, stall, br_res, br_mp;
  logic [31:0]   current_ipc;
  logic [7:0]    hit_rate;
  logic          any_active, bottleneck, high_power, good_bp, window_valid;

  perf_stats_collector #(.NUM_CORES(NC), .WINDOW_LOG2(WL), .HIGH_POWER_IPC(HP)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .enable_i              (enable),
    .core_active_i         (core_active),
    .instr_retired_i       (retired),
    .l1_access_i           (l1_access),
    .l1_hit_i              (l1_hit),
    .stall_i               (stall),
    .branch_resolved_i     (br_res),
    .branch_mispredict_i   (br_mp),
    .current_ipc_o         (current_ipc),
    .cache_hit_rate_l1_o   (hit_rate),
    .any_core_active_o     (any_active),
    .pipeline_bottleneck_o (bottleneck),
    .high_power_mode_o     (high_power),
    .good_bp_o             (good_bp),
    .window_valid_o        (window_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] ipc;
    logic [7:0]  rate;
    logic        bn, hp, gb;
    int          edge_n;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_pub;
  int   checks = 0, errors = 0, edge_cnt = 0;
  logic exp_act;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(posedge clk or posedge rst)
    if (rst) exp_act <= 1'b0;
    else     exp_act <= |core_active;

  // Monitor: compare every published window against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("any_core_active", 32'(any_active), 32'(exp_act));
      if (window_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window_valid: pulse with no window pending at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("ipc",           current_ipc,      32'(e.ipc));
          check("hit_rate",      32'(hit_rate),    32'(e.rate));
          check("bottleneck",    32'(bottleneck),  32'(e.bn));
          check("high_power",    32'(high_power),  32'(e.hp));
          check("good_bp",       32'(good_bp),     32'(e.gb));
          check("publish_cycle", 32'(edge_cnt),    32'(e.edge_n));
          last_pub = e;
        end
      end
    end
  end

  task automatic clear_events();
    retired = '0; l1_access = '0; l1_hit = '0; stall = '0; br_res = '0; br_mp = '0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      clear_events();
      core_active = NC'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic start();
    enable = 1'b1;
    idle_cycles(1);
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      core_active = NC'($urandom); retired = NC'($urandom); l1_access = NC'($urandom);
      l1_hit = NC'($urandom); stall = NC'($urandom); br_res = NC'($urandom); br_mp = NC'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // Drives one full window and, if it is expected to publish, queues its results.
  task automatic run_window(input int mode, input bit pub);
    int   ret = 0, acc = 0, hit = 0, stl = 0, br = 0, mp = 0, ipc_full;
    exp_t e;
    for (int i = 0; i < WIN; i++) begin
      clear_events();
      core_active = NC'($urandom);
      case (mode)
        0: begin
          retired = NC'($urandom); l1_access = NC'($urandom); l1_hit = NC'($urandom);
          stall = NC'($urandom); br_res = NC'($urandom); br_mp = NC'($urandom);
        end
        1: retired = 2'b01;
        2: begin
          retired = 2'b11; l1_access = 2'b01; l1_hit = (i < 48) ? 2'b01 : 2'b00;
        end
        3: begin
          retired = 2'b11; l1_access = (i < 7) ? 2'b01 : 2'b00; l1_hit = (i < 3) ? 2'b11 : 2'b00;
        end
        4: begin
          stall = (i < 32) ? 2'b11 : 2'b00; br_res = (i < 32) ? 2'b01 : 2'b00;
          br_mp = (i == 0) ? 2'b11 : ((i == 40) ? 2'b01 : 2'b00);
        end
        5: begin
          stall = (i < 31) ? 2'b11 : 2'b00; br_res = (i < 32) ? 2'b10 : 2'b00;
          br_mp = (i < 2) ? 2'b10 : 2'b00;
        end
        6: begin
          l1_hit = NC'($urandom); br_mp = NC'($urandom);
        end
        default: retired = (i < WIN - 1) ? 2'b01 : 2'b10;
      endcase
      ret += $countones(retired);
      acc += $countones(l1_access);
      hit += $countones(l1_access & l1_hit);
      stl += $countones(stall);
      br  += $countones(br_res);
      mp  += $countones(br_res & br_mp);
      @(posedge clk); #1;
    end
    if (pub) begin
      ipc_full = ret >> (WL - 4);
      e.ipc    = (ipc_full > 4095) ? 12'hFFF : 12'(ipc_full);
      e.rate   = (acc == 0) ? 8'd0 : 8'((hit * 100) / acc);
      e.bn     = stl >= NC * (1 << (WL - 1));
      e.hp     = e.ipc >= HP;
      e.gb     = (br != 0) && (mp * 16 < br);
      e.edge_n = edge_cnt + 9;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_held();
    check("held_ipc",        current_ipc,      32'(last_pub.ipc));
    check("held_hit_rate",   32'(hit_rate),    32'(last_pub.rate));
    check("held_bottleneck", 32'(bottleneck),  32'(last_pub.bn));
    check("held_high_power", 32'(high_power),  32'(last_pub.hp));
    check("held_good_bp",    32'(good_bp),     32'(last_pub.gb));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ipc"},          current_ipc,        32'd0);
    check({tag, "_hit_rate"},     32'(hit_rate),      32'd0);
    check({tag, "_any_active"},   32'(any_active),    32'd0);
    check({tag, "_bottleneck"},   32'(bottleneck),    32'd0);
    check({tag, "_high_power"},   32'(high_power),    32'd0);
    check({tag, "_good_bp"},      32'(good_bp),       32'd0);
    check({tag, "_window_valid"}, 32'(window_valid),  32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    core_active = '1;
    clear_events();
    last_pub = '{default: '0};
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    idle_cycles(2);

    // Directed windows back to back, then randomized ones.
    start();
    for (int m = 1; m <= 6; m++) run_window(m, 1'b1);
    repeat (4) run_window(0, 1'b1);

    // Drop enable during the divide of a finished window: nothing may publish.
    run_window(0, 1'b0);
    idle_cycles(2);
    enable = 1'b0;
    idle_cycles(20);
    check_held();

    // Re-enable: a fresh full window publishes 64+10 cycles later.
    start();
    run_window(2, 1'b1);
    idle_cycles(12);

    // Asynchronous reset in the middle of a window with nonzero outputs.
    random_cycles(20);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    last_pub = '{default: '0};
    enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(2);

    // A retire in the window's final cycle counts toward that window.
    start();
    run_window(7, 1'b1);
    idle_cycles(12);
    enable = 1'b0;
    idle_cycles(3);

    check("pending_publishes", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
